// File: rtl/instruction_issuer.sv
// ---------------------------------------------------------------------------
// instruction_issuer
//   Buffers 11-bit instructions in a small FIFO and hands them one at a time
//   to a control circuit. Each instruction is held on INSTRUCTION until the
//   control circuit answers with Done. One NOP cycle (GAP) separates
//   consecutive instructions. If Done does not arrive within TIMEOUT cycles,
//   the issuer parks in ERROR until clear or reset.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-high reset
//   clear        in   synchronous flush: empties FIFO, clears error/overflow
//   wr_en        in   FIFO write strobe
//   wr_data      in   instruction {opcode[10:8], Rx[7:4], Ry/imm[3:0]}
//   run          in   allows a new instruction to start
//   Done         in   completion from control circuit (used only in WAIT)
//   INSTRUCTION  out  registered instruction, NOP whenever not in WAIT
//   busy         out  state != IDLE
//   full, empty  out  FIFO status
//   count        out  FIFO occupancy, 0..DEPTH
//   retired      out  completed-instruction counter, wraps 255 -> 0
//   error        out  sticky timeout flag
//   overflow     out  sticky dropped-write flag
// ---------------------------------------------------------------------------
module instruction_issuer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [10:0]              wr_data,
  input  logic                     run,
  input  logic                     Done,
  output logic [10:0]              INSTRUCTION,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               retired,
  output logic                     error,
  output logic                     overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [10:0] NOP = 11'b111_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GAP   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [10:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [10:0]      r_instr;
  logic [WCW-1:0]   r_wcnt;
  logic [7:0]       r_retired;
  logic             r_error;
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_retire;
  logic             w_timeout;
  logic [WCW-1:0]   w_wcnt_inc;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_wcnt_inc = r_wcnt + 1'b1;

  // A write into a full FIFO is only accepted when the head leaves the same
  // edge; clear discards any write presented with it.
  assign w_push = wr_en && !clear && (!w_full || w_pop);
  assign w_drop = wr_en && !clear &&  w_full && !w_pop;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_retire    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        // empty reflects occupancy before this edge, so a word written now
        // cannot be issued until the next edge.
        if (run && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        // Done takes priority over a timeout landing on the same edge.
        if (Done) begin
          w_retire    = 1'b1;
          w_state_nxt = S_GAP;
        end else if (w_wcnt_inc == WCW'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ERROR;
        end
      end
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_pop       = 1'b0;
      w_retire    = 1'b0;
      w_timeout   = 1'b0;
    end
  end

  // FIFO storage: payload only, needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Control and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_instr    <= NOP;
      r_wcnt     <= '0;
      r_retired  <= '0;
      r_error    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_instr    <= NOP;
      r_wcnt     <= '0;
      r_error    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_instr <= r_mem[r_rd_ptr];
      end else if (w_retire || w_timeout) begin
        r_instr <= NOP;
      end

      if (w_pop) begin
        r_wcnt <= '0;
      end else if (r_state == S_WAIT && !Done) begin
        r_wcnt <= w_wcnt_inc;
      end

      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign INSTRUCTION = r_instr;
  assign busy        = (r_state != S_IDLE);
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign retired     = r_retired;
  assign error       = r_error;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_instruction_issuer.sv
// ---------------------------------------------------------------------------
// tb_instruction_issuer
//   Directed self-checking bench for instruction_issuer (DEPTH=8, TIMEOUT=15).
// ---------------------------------------------------------------------------
module tb_instruction_issuer;

  localparam logic [10:0] NOP = 11'b111_0000_0000;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        wr_en;
  logic [10:0] wr_data;
  logic        run;
  logic        Done;
  logic [10:0] INSTRUCTION;
  logic        busy;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic [7:0]  retired;
  logic        error;
  logic        overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_ret = 0;

  instruction_issuer #(.DEPTH(8), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .run         (run),
    .Done        (Done),
    .INSTRUCTION (INSTRUCTION),
    .busy        (busy),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .retired     (retired),
    .error       (error),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [10:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // From IDLE/GAP with run=1: issue the head, compare it, then retire it.
  task automatic issue_retire(input string tag, input logic [10:0] exp);
    step();
    chk(tag, INSTRUCTION, exp);
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret = (exp_ret + 1) % 256;
    chk({tag, "_nop"}, INSTRUCTION, NOP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0; run = 1'b0; Done = 1'b0;
    step(); step();
    chk("rst_instr", INSTRUCTION, NOP);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retired", retired, 0);
    chk("rst_err_ovf", {error, overflow}, 0);
    reset = 1'b0;
    step();

    // Two instructions back to back
    push(11'h016);
    push(11'h112);
    chk("t1_count", count, 2);
    run = 1'b1;
    step();
    chk("t1_first", INSTRUCTION, 11'h016);
    chk("t1_busy", busy, 1);
    step(); step();
    chk("t1_held", INSTRUCTION, 11'h016);
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    chk("t1_gap_nop", INSTRUCTION, NOP);
    step();
    chk("t1_second", INSTRUCTION, 11'h112);
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    step();
    chk("t1_retired", retired, 2);
    chk("t1_empty", empty, 1);
    chk("t1_idle", busy, 0);
    run = 1'b0;

    // Fill to full, ninth write dropped
    for (int i = 0; i < 8; i++) push(11'h100 + 11'(i));
    chk("t2_full", full, 1);
    chk("t2_count8", count, 8);
    chk("t2_no_ovf", overflow, 0);
    push(11'h1FF);
    chk("t2_ovf", overflow, 1);
    chk("t2_count_hold", count, 8);
    run = 1'b1;
    for (int i = 0; i < 8; i++) issue_retire("t2_drain", 11'h100 + 11'(i));
    step();
    chk("t2_empty", empty, 1);
    chk("t2_retired", retired, exp_ret);
    run = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t2_clr_ovf", overflow, 0);
    chk("t2_keep_ret", retired, exp_ret);

    // Pop and write on the same edge while full
    for (int i = 0; i < 8; i++) push(11'h200 + 11'(i));
    run = 1'b1;
    step();
    chk("t3_issue0", INSTRUCTION, 11'h200);
    chk("t3_count7", count, 7);
    push(11'h208);
    chk("t3_refull", full, 1);
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    wr_en = 1'b1;
    wr_data = 11'h2AA;
    step();
    wr_en = 1'b0;
    chk("t3_count_same", count, 8);
    chk("t3_no_ovf", overflow, 0);
    chk("t3_issue1", INSTRUCTION, 11'h201);
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    for (int k = 2; k <= 8; k++) issue_retire("t3_order", 11'h200 + 11'(k));
    issue_retire("t3_new_entry", 11'h2AA);
    step();
    chk("t3_empty", empty, 1);
    chk("t3_retired", retired, exp_ret);

    // Timeout into ERROR
    run = 1'b0;
    push(11'h234);
    run = 1'b1;
    step();
    chk("t4_issue", INSTRUCTION, 11'h234);
    repeat (14) step();
    chk("t4_not_yet", error, 0);
    chk("t4_still_held", INSTRUCTION, 11'h234);
    step();
    chk("t4_error", error, 1);
    chk("t4_nop", INSTRUCTION, NOP);
    chk("t4_busy", busy, 1);
    Done = 1'b1;
    step();
    Done = 1'b0;
    chk("t4_done_ignored", retired, exp_ret);
    chk("t4_err_sticky", error, 1);
    push(11'h0AB);
    chk("t4_write_in_err", count, 1);
    clear = 1'b1;
    wr_en = 1'b1;
    wr_data = 11'h0CD;
    step();
    clear = 1'b0;
    wr_en = 1'b0;
    chk("t4_clr_err", error, 0);
    chk("t4_clr_count", count, 0);
    chk("t4_clr_idle", busy, 0);

    // Done on the same edge the timeout would fire
    run = 1'b0;
    push(11'h345);
    run = 1'b1;
    step();
    repeat (14) step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    chk("t5_no_err", error, 0);
    chk("t5_retired", retired, exp_ret);
    chk("t5_nop", INSTRUCTION, NOP);
    step();

    // run dropped during WAIT
    run = 1'b0;
    push(11'h051);
    push(11'h052);
    push(11'h053);
    run = 1'b1;
    step();
    run = 1'b0;
    chk("t6_issue", INSTRUCTION, 11'h051);
    step(); step();
    chk("t6_not_abort", INSTRUCTION, 11'h051);
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_ret++;
    chk("t6_retired", retired, exp_ret);
    chk("t6_gap_busy", busy, 1);
    step();
    chk("t6_idle", busy, 0);
    step(); step();
    chk("t6_held_count", count, 2);
    chk("t6_nop", INSTRUCTION, NOP);
    run = 1'b1;
    step();
    chk("t6_resume", INSTRUCTION, 11'h052);

    // Asynchronous reset in the middle of WAIT
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ret = 0;
    run = 1'b0;
    for (int i = 0; i < 4; i++) push(11'h060 + 11'(i));
    run = 1'b1;
    for (int i = 0; i < 3; i++) issue_retire("t7_pre", 11'h060 + 11'(i));
    chk("t7_ret3", retired, 3);
    step();
    chk("t7_waiting", INSTRUCTION, 11'h063);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_async_nop", INSTRUCTION, NOP);
    chk("t7_async_ret", retired, 0);
    chk("t7_async_empty", empty, 1);
    chk("t7_async_busy", busy, 0);
    step();
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_issuer.md
INSTRUCTION_ISSUER -- requirements
Module: instruction_issuer

Interface
REQ-001 Parameter DEPTH, 8, instruction FIFO entries (power of two, >=2) SHALL be supported.
REQ-002 Parameter TIMEOUT, 15, max WAIT cycles before error SHALL be supported.
REQ-003 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset SHALL force the reset state immediately.
REQ-005 clear  in  1  synchronous flush/error clear SHALL be provided.
REQ-006 wr_en  in  1  FIFO write strobe SHALL be provided.
REQ-007 wr_data  in  11  instruction {opcode[10:8], Rx[7:4], Ry/imm[3:0]} SHALL be provided.
REQ-008 run  in  1  enable for starting new instructions SHALL be provided.
REQ-009 Done  in  1  completion from control circuit SHALL be provided.
REQ-010 INSTRUCTION  out  11  registered instruction presented to control circuit SHALL be provided.
REQ-011 busy  out  1  state != IDLE SHALL be flagged.
REQ-012 full, empty  out  1 each  FIFO status SHALL be provided.
REQ-013 count  out  log2(DEPTH)+1  FIFO occupancy SHALL be provided.
REQ-014 retired  out  8  completed-instruction counter SHALL be provided.
REQ-015 error, overflow  out  1 each  sticky timeout / dropped-write flags SHALL be provided.

Function
REQ-016 NOP SHALL be 11'b111_0000_0000 (unused opcode, ignored by control circuit); INSTRUCTION SHALL be NOP whenever not in WAIT.
REQ-017 FSM states SHALL be IDLE, WAIT, GAP, ERROR.
REQ-018 IDLE/GAP: at edge with run=1 and empty=0, head SHALL pop into INSTRUCTION, state->WAIT, wait counter=0; otherwise GAP->IDLE, IDLE holds.
REQ-019 WAIT: INSTRUCTION SHALL be held stable; Done=1 at edge -> retired+1 (wraps 255->0), INSTRUCTION=NOP, state->GAP.
REQ-020 WAIT: Done=0 at edge -> wait counter +1; counter reaching TIMEOUT SHALL give state->ERROR, error=1, INSTRUCTION=NOP.
REQ-021 Done=1 and counter reaching TIMEOUT same edge: Done SHALL win (retire, GAP).
REQ-022 Done outside WAIT SHALL be ignored; run=0 in WAIT SHALL NOT abort the instruction.
REQ-023 ERROR SHALL hold until clear or reset; FIFO writes SHALL still be accepted in ERROR.
REQ-024 Write with wr_en=1 and full=0 SHALL push wr_data; write when full with no pop that edge SHALL be dropped and set overflow.
REQ-025 Simultaneous pop and write when full SHALL accept both; count unchanged, overflow unchanged.
REQ-026 Write when empty SHALL NOT be popped the same edge; earliest issue is next edge.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-028 clear SHALL empty FIFO, clear error/overflow, state->IDLE, INSTRUCTION=NOP; retired SHALL be kept; clear SHALL override writes that edge.

Reset
REQ-029 On reset: state IDLE, INSTRUCTION=NOP, count=0, empty=1, full=0, busy=0, retired=0, error=0, overflow=0, pointers 0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the instruction without incrementing retired.

Verification
REQ-031 Write {000,0001,0110},{001,0001,0010}, run=1 -> first on INSTRUCTION next edge, held until Done pulse, one NOP cycle, second issued; retired=2, empty=1.
REQ-032 Write 8 entries, 9th with no pop -> full=1, count=8, overflow=1, 9th never issued.
REQ-033 Issue {010,0011,0100}, Done held 0 -> after 15 WAIT cycles error=1, INSTRUCTION=NOP; clear -> IDLE, error=0, count=0.
REQ-034 run=0 during WAIT, Done pulse -> retired+1, state GAP->IDLE, remaining entries not issued until run=1.
REQ-035 FIFO full, WAIT completes and pops while wr_en=1 same edge -> count stays 8, overflow=0, new entry issued in order.
REQ-036 Reset asserted mid-WAIT after retired=3 -> INSTRUCTION=NOP, retired=0, empty=1 asynchronously.
